dma_channel_scheduler: RTL and testbench

DMA_CHANNEL_SCHEDULER -- requirements
Module: dma_channel_scheduler

---
 rtl/dma_channel_scheduler.sv | 141 ++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_scheduler.sv
// DMA channel scheduler: arbitrates started channels onto a single DMA core command port.
// Define DMA_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dma_channel_scheduler #(
    parameter int CHANNELS = 4,
    parameter int TL_AW    = 32
) (
    input  logic                        dmac_clock_i,
    input  logic                        dmac_reset_ni,
    input  logic                        cfg_we_i,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch_i,
    input  logic [TL_AW-1:0]            cfg_src_i,
    input  logic [TL_AW-1:0]            cfg_dst_i,
    input  logic [TL_AW-1:0]            cfg_len_i,
    input  logic                        cfg_strd_i,
    input  logic                        cfg_stwr_i,
    output logic                        cfg_err_o,
    input  logic [CHANNELS-1:0]         chn_start_i,
    output logic [CHANNELS-1:0]         chn_pending_o,
    output logic [CHANNELS-1:0]         chn_done_o,
    output logic [CHANNELS-1:0]         chn_err_o,
    output logic                        sched_busy_o,
    output logic                        dmac_tx_o,
    output logic [TL_AW-1:0]            dmac_source_address_o,
    output logic [TL_AW-1:0]            dmac_dest_address_o,
    output logic [TL_AW-1:0]            dmac_bytes_tx_o,
    output logic                        dmac_stationary_rd_o,
    output logic                        dmac_stationary_wr_o,
    input  logic                        dmac_busy_i,
    input  logic                        dmac_done_i,
    input  logic                        dmac_err_i
);
    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e              state_q;
    logic [CW-1:0]       active_q;
    logic [CHANNELS-1:0] pending_q;
`ifndef DMA_SCHED_FIXED_PRIO_EN
    logic [CW-1:0]       rr_ptr_q;
`endif

    logic [TL_AW-1:0]    desc_src [CHANNELS];
    logic [TL_AW-1:0]    desc_dst [CHANNELS];
    logic [TL_AW-1:0]    desc_len [CHANNELS];
    logic [CHANNELS-1:0] desc_strd;
    logic [CHANNELS-1:0] desc_stwr;

    logic                grant_vld;
    logic [CW-1:0]       grant_ch;
    logic [CW-1:0]       cand;
    logic [CHANNELS-1:0] grant_mask;
    logic [CHANNELS-1:0] active_mask;
    logic                cfg_reject;
    logic                zero_len;
    logic                core_fall;
    logic                unused_done;

    assign unused_done  = dmac_done_i;
    assign active_mask  = (state_q != IDLE) ? (CHANNELS'(1) << active_q) : '0;
    assign grant_mask   = (state_q == IDLE && grant_vld) ? (CHANNELS'(1) << grant_ch) : '0;
    assign cfg_reject   = pending_q[cfg_ch_i] | active_mask[cfg_ch_i];
    assign zero_len     = (dmac_bytes_tx_o == '0);
    // Completion is the busy falling edge only; the core's sticky done flag is ignored.
    assign core_fall    = (state_q == WAIT_DONE) && !dmac_busy_i;
    assign chn_done_o   = (core_fall || (state_q == ISSUE && zero_len)) ? active_mask : '0;
    assign chn_err_o    = (core_fall && dmac_err_i) ? active_mask : '0;
    assign chn_pending_o = pending_q;
    assign sched_busy_o = (state_q != IDLE);

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
`ifdef DMA_SCHED_FIXED_PRIO_EN
            cand = CW'(k);
`else
            cand = CW'((32'(rr_ptr_q) + 1 + k) % CHANNELS);
`endif
            if (!grant_vld && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    // Descriptors carry no reset value; they survive a scheduler reset.
    always_ff @(posedge dmac_clock_i) begin
        if (cfg_we_i && !cfg_reject) begin
            desc_src[cfg_ch_i]  <= cfg_src_i;
            desc_dst[cfg_ch_i]  <= cfg_dst_i;
            desc_len[cfg_ch_i]  <= cfg_len_i;
            desc_strd[cfg_ch_i] <= cfg_strd_i;
            desc_stwr[cfg_ch_i] <= cfg_stwr_i;
        end
    end

    always_ff @(posedge dmac_clock_i or negedge dmac_reset_ni) begin
        if (!dmac_reset_ni) begin
            state_q               <= IDLE;
            active_q              <= '0;
            pending_q             <= '0;
            cfg_err_o             <= 1'b0;
            dmac_tx_o             <= 1'b0;
            dmac_source_address_o <= '0;
            dmac_dest_address_o   <= '0;
            dmac_bytes_tx_o       <= '0;
            dmac_stationary_rd_o  <= 1'b0;
            dmac_stationary_wr_o  <= 1'b0;
`ifndef DMA_SCHED_FIXED_PRIO_EN
            rr_ptr_q              <= CW'(CHANNELS - 1);
`endif
        end else begin
            cfg_err_o <= cfg_we_i & cfg_reject;
            pending_q <= (pending_q & ~grant_mask) | (chn_start_i & ~pending_q & ~active_mask);
            dmac_tx_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        state_q               <= ISSUE;
                        active_q              <= grant_ch;
                        dmac_source_address_o <= desc_src[grant_ch];
                        dmac_dest_address_o   <= desc_dst[grant_ch];
                        dmac_bytes_tx_o       <= desc_len[grant_ch];
                        dmac_stationary_rd_o  <= desc_strd[grant_ch];
                        dmac_stationary_wr_o  <= desc_stwr[grant_ch];
                        dmac_tx_o             <= (desc_len[grant_ch] != '0);
`ifndef DMA_SCHED_FIXED_PRIO_EN
                        rr_ptr_q              <= grant_ch;
`endif
                    end
                end
                ISSUE:     state_q <= zero_len ? IDLE : WAIT_BUSY;
                WAIT_BUSY: if (dmac_busy_i) state_q <= WAIT_DONE;
                WAIT_DONE: if (!dmac_busy_i) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler: vector table, directed corner sequences,
// and randomized start masks checked against a transaction-level arbitration model.
module tb_dma_channel_scheduler;
    localparam int CH = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [AW-1:0] cfg_src, cfg_dst, cfg_len;
    logic          cfg_strd, cfg_stwr;
    logic          cfg_err_o;
    logic [CH-1:0] chn_start;
    logic [CH-1:0] chn_pending_o, chn_done_o, chn_err_o;
    logic          sched_busy_o, dmac_tx_o;
    logic [AW-1:0] dmac_source_address_o, dmac_dest_address_o, dmac_bytes_tx_o;
    logic          dmac_stationary_rd_o, dmac_stationary_wr_o;
    logic          dmac_busy, dmac_done, dmac_err;

    int errors = 0;
    int checks = 0;
    int unsigned model_last;

    logic [AW-1:0] sh_src [CH];
    logic [AW-1:0] sh_dst [CH];
    logic [AW-1:0] sh_len [CH];
    logic          sh_rd  [CH];
    logic          sh_wr  [CH];

    typedef struct {
        int unsigned   ch;
        logic [AW-1:0] src, dst, len;
        logic          rd, wr;
        int unsigned   pre, busy;
        logic          err;
        logic          exp_tx;
        logic [CH-1:0] exp_done, exp_err;
    } vec_t;

    dma_channel_scheduler #(.CHANNELS(CH), .TL_AW(AW)) dut (
        .dmac_clock_i          (clk),
        .dmac_reset_ni         (rst_n),
        .cfg_we_i              (cfg_we),
        .cfg_ch_i              (cfg_ch),
        .cfg_src_i             (cfg_src),
        .cfg_dst_i             (cfg_dst),
        .cfg_len_i             (cfg_len),
        .cfg_strd_i            (cfg_strd),
        .cfg_stwr_i            (cfg_stwr),
        .cfg_err_o             (cfg_err_o),
        .chn_start_i           (chn_start),
        .chn_pending_o         (chn_pending_o),
        .chn_done_o            (chn_done_o),
        .chn_err_o             (chn_err_o),
        .sched_busy_o          (sched_busy_o),
        .dmac_tx_o             (dmac_tx_o),
        .dmac_source_address_o (dmac_source_address_o),
        .dmac_dest_address_o   (dmac_dest_address_o),
        .dmac_bytes_tx_o       (dmac_bytes_tx_o),
        .dmac_stationary_rd_o  (dmac_stationary_rd_o),
        .dmac_stationary_wr_o  (dmac_stationary_wr_o),
        .dmac_busy_i           (dmac_busy),
        .dmac_done_i           (dmac_done),
        .dmac_err_i            (dmac_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, {dmac_source_address_o, dmac_dest_address_o}, 0);
        chk({tag, "_len"}, dmac_bytes_tx_o, 0);
        chk({tag, "_ctl"}, {cfg_err_o, chn_pending_o, chn_done_o, chn_err_o, sched_busy_o,
                            dmac_tx_o, dmac_stationary_rd_o, dmac_stationary_wr_o}, 0);
    endtask

    // Arbitration model: which pending channel wins given the last granted channel.
    function automatic int unsigned pick(input logic [CH-1:0] pend, input int unsigned last);
`ifdef DMA_SCHED_FIXED_PRIO_EN
        for (int unsigned i = 0; i < CH; i++) if (pend[i]) return i;
`else
        for (int unsigned k = 1; k <= CH; k++) if (pend[(last + k) % CH]) return (last + k) % CH;
`endif
        return 0;
    endfunction

    function automatic vec_t mk(input int unsigned ch, input int unsigned pre,
                                input int unsigned busy, input logic err);
        vec_t v;
        v.ch = ch; v.src = sh_src[ch]; v.dst = sh_dst[ch]; v.len = sh_len[ch];
        v.rd = sh_rd[ch]; v.wr = sh_wr[ch]; v.pre = pre; v.busy = busy; v.err = err;
        v.exp_tx   = (sh_len[ch] != 0);
        v.exp_done = CH'(1) << ch;
        v.exp_err  = (err && v.exp_tx) ? (CH'(1) << ch) : '0;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; cfg_we = 1'b0; chn_start = '0;
        dmac_busy = 1'b0; dmac_done = 1'b0; dmac_err = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_last = CH - 1;
        @(negedge clk);
    endtask

    task automatic cfg(input int unsigned ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW-1:0] l, input logic rd, input logic wr, input logic exp_err);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_src = s; cfg_dst = d; cfg_len = l;
        cfg_strd = rd; cfg_stwr = wr;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err_pulse", cfg_err_o, exp_err);
        @(negedge clk);
        chk("cfg_err_single", cfg_err_o, 0);
        if (!exp_err) begin
            sh_src[ch] = s; sh_dst[ch] = d; sh_len[ch] = l; sh_rd[ch] = rd; sh_wr[ch] = wr;
        end
    endtask

    task automatic start(input logic [CH-1:0] m);
        chn_start = m;
        @(negedge clk);
        chn_start = '0;
    endtask

    // Plays the DMA core for one expected grant and checks the scheduler around it.
    task automatic serve(input vec_t v, input bit poke, input bit same_start, output int waited);
        bit seen = 1'b0;
        int unsigned other = (v.ch + 1) % CH;
        waited = -1;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (dmac_tx_o || chn_done_o != '0) begin
                seen = 1'b1;
                waited = t;
            end
        end
        chk("grant_timeout", seen, 1);
        if (!seen) return;
        chk("tx_pulse", dmac_tx_o, v.exp_tx);
        if (v.exp_tx) begin
            chk("src", dmac_source_address_o, v.src);
            chk("dst", dmac_dest_address_o, v.dst);
            chk("len", dmac_bytes_tx_o, v.len);
            chk("flags", {dmac_stationary_rd_o, dmac_stationary_wr_o}, {v.rd, v.wr});
            chk("no_done_at_issue", chn_done_o, 0);
            @(negedge clk);
            chk("tx_single", dmac_tx_o, 0);
            for (int unsigned p = 0; p < v.pre; p++) begin
                @(negedge clk);
                chk("no_done_before_busy", chn_done_o, 0);
            end
            dmac_busy = 1'b1;
            if (poke) begin
                cfg(v.ch, 32'hDEAD_0000, 32'hBEEF_0000, 32'h0000_0999, 1'b1, 1'b1, 1'b1);
                start(CH'(1) << v.ch);
                start(CH'(1) << other);
                chk("start_on_active_ignored", chn_pending_o, CH'(1) << other);
                cfg(other, 32'hDEAD_1111, 32'hBEEF_1111, 32'h0000_0777, 1'b0, 1'b0, 1'b1);
            end
            for (int unsigned b = 0; b < v.busy; b++) begin
                @(negedge clk);
                chk("no_done_while_busy", chn_done_o, 0);
                chk("src_stable", dmac_source_address_o, v.src);
                chk("len_stable", dmac_bytes_tx_o, v.len);
                chk("sched_busy", sched_busy_o, 1);
            end
            dmac_busy = 1'b0;
            dmac_err  = v.err;
            chn_start = same_start ? (CH'(1) << v.ch) : '0;
            #1;
            chk("done_at_busy_fall", chn_done_o, v.exp_done);
            chk("err_at_busy_fall", chn_err_o, v.exp_err);
            dmac_done = 1'b1;
        end else begin
            chk("zero_len_done", chn_done_o, v.exp_done);
            chk("zero_len_err", chn_err_o, v.exp_err);
        end
        @(negedge clk);
        dmac_err  = 1'b0;
        chn_start = '0;
        chk("done_single", chn_done_o, 0);
        chk("granted_not_pending", chn_pending_o[v.ch], 0);
        model_last = v.ch;
    endtask

    vec_t tbl [5];
    vec_t v;
    int   w;
    bit   seen;
    logic [CH-1:0] p;
    int unsigned c;

    initial begin
        tbl[0] = '{1, 32'h0000_1000, 32'h0000_2000, 32'h0000_0040, 1'b0, 1'b0, 1, 10, 1'b0, 1'b1, 4'b0010, 4'b0000};
        tbl[1] = '{3, 32'h0000_A000, 32'h0000_B000, 32'h0000_0008, 1'b1, 1'b0, 0, 3,  1'b1, 1'b1, 4'b1000, 4'b1000};
        tbl[2] = '{2, 32'h0000_3000, 32'h0000_4000, 32'h0000_0000, 1'b0, 1'b0, 0, 2,  1'b1, 1'b0, 4'b0100, 4'b0000};
        tbl[3] = '{0, 32'h1234_5678, 32'h8765_4321, 32'h0000_0001, 1'b0, 1'b1, 2, 1,  1'b0, 1'b1, 4'b0001, 4'b0000};
        tbl[4] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 2,  1'b0, 1'b1, 4'b0100, 4'b0000};

        do_reset();

        foreach (tbl[i]) begin
            cfg(tbl[i].ch, tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].rd, tbl[i].wr, 1'b0);
            start(CH'(1) << tbl[i].ch);
            chk("pending_after_start", chn_pending_o, CH'(1) << tbl[i].ch);
            serve(tbl[i], 1'b0, 1'b0, w);
        end

        // Writes to active/pending channels are rejected; restarts on an active channel are ignored.
        cfg(0, 32'h0000_5000, 32'h0000_6000, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        cfg(1, 32'h0000_7000, 32'h0000_8000, 32'h0000_0020, 1'b1, 1'b1, 1'b0);
        start(4'b0001);
        serve(mk(0, 0, 3, 1'b0), 1'b1, 1'b1, w);
        serve(mk(1, 1, 2, 1'b0), 1'b0, 1'b0, w);
        chk("no_stray_pending", chn_pending_o, 0);
        start(4'b0001);
        serve(mk(0, 0, 2, 1'b0), 1'b0, 1'b0, w);
        cfg(2, 32'h0000_9000, 32'h0000_9100, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        start(4'b0100);
        serve(mk(2, 0, 1, 1'b0), 1'b0, 1'b0, w);

        // Reset while the core is busy with two more channels queued.
        cfg(3, 32'h0000_C000, 32'h0000_D000, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        start(4'b1000);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            seen = dmac_tx_o;
        end
        chk("rst_seq_tx_timeout", seen, 1);
        @(negedge clk);
        dmac_busy = 1'b1;
        repeat (3) @(negedge clk);
        start(4'b0110);
        chk("rst_seq_pending", chn_pending_o, 4'b0110);
        chk("rst_seq_busy", sched_busy_o, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_xfer");
        @(negedge clk);
        dmac_busy = 1'b0;
        #1;
        check_all_zero("reset_busy_fall");
        @(negedge clk);
        rst_n = 1'b1;
        model_last = CH - 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("after_reset_quiet", {chn_done_o, chn_pending_o, dmac_tx_o, sched_busy_o}, 0);
        end

        // All four channels started together, twice: order 0,1,2,3 each time.
        for (int r = 0; r < 2; r++) begin
            for (int unsigned ch = 0; ch < CH; ch++)
                cfg(ch, 32'h0001_0000 + ch * 32'h100 + r, 32'h0002_0000 + ch, 32'h10 + ch, 1'b0, 1'b0, 1'b0);
            start(4'b1111);
            chk("all_pending", chn_pending_o, 4'b1111);
            for (int unsigned ch = 0; ch < CH; ch++) begin
                serve(mk(ch, 0, 2, 1'b0), 1'b0, 1'b0, w);
                chk("order_gap", w, 0);
            end
        end

        // Random start masks against the arbitration model.
        for (int r = 0; r < 30; r++) begin
            p = CH'($urandom_range(1, 15));
            for (int unsigned ch = 0; ch < CH; ch++)
                if (p[ch])
                    cfg(ch, $urandom, $urandom,
                        ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(1, 4096)),
                        1'($urandom), 1'($urandom), 1'b0);
            start(p);
            chk("rand_pending", chn_pending_o, p);
            while (p != '0) begin
                c = pick(p, model_last);
                p[c] = 1'b0;
                serve(mk(c, $urandom_range(0, 2), $urandom_range(1, 6), 1'($urandom)), 1'b0, 1'b0, w);
            end
            chk("rand_drained", chn_pending_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
